button_bounce_emulator: RTL

Synthesizable contact-bounce source for on-board and simulation self-test of the push-button debouncing path.
- Takes a clean level request (clean_in) and drives pb_out into the debouncer's pb input.
- On each level change, pb_out chatters pseudo-randomly for a fixed window, then settles to the requested level.
- Gives the debouncer a repeatable, seedable stimulus without a physical button.

---
 rtl/button_bounce_emulator.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/button_bounce_emulator.sv
// -----------------------------------------------------------------------------
// button_bounce_emulator
//
// Purpose:
//   Contact-bounce source used to exercise a push-button debouncer without a
//   physical button. A clean level request (clean_in) is turned into a
//   chattering pb_out. On every level change pb_out first jumps to the new
//   level (first contact) and then toggles pseudo-randomly for BOUNCE_CYCLES
//   cycles. After that window it settles to the requested level. The chatter
//   pattern comes from a seedable 16-bit Galois LFSR, so every run is
//   repeatable.
//
// Parameters:
//   BOUNCE_CYCLES : bounce window length in in_clk cycles (2..65535)
//   HOLD_BITS     : LFSR field width selecting segment length (1..2^HOLD_BITS)
//   LFSR_SEED     : LFSR reset value (0 is replaced by 16'h0001)
//
// Ports:
//   in_clk       in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   clean_in     in   requested button level (synchronous to in_clk)
//   pb_out       out  bouncy level toward the debouncer (registered)
//   busy         out  high while the bounce window is active (registered)
//   settled      out  one-cycle pulse when pb_out reaches its final level
//   bounce_count out  [7:0] rule-(c) toggles since the last change, saturating
//                     (only when BOUNCE_COUNT_EN is defined)
//
// Configuration macro:
//   BOUNCE_COUNT_EN : adds the bounce_count output and its counter.
// -----------------------------------------------------------------------------
module button_bounce_emulator #(
  parameter int          BOUNCE_CYCLES = 64,
  parameter int          HOLD_BITS     = 3,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic       in_clk,
  input  logic       rst,
  input  logic       clean_in,
  output logic       pb_out,
  output logic       busy,
`ifdef BOUNCE_COUNT_EN
  output logic [7:0] bounce_count,
`endif
  output logic       settled
);

  // A zero seed would lock the LFSR at zero forever.
  localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0] WIN_LOAD = 16'(BOUNCE_CYCLES - 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    BOUNCE = 1'b1
  } state_t;

  state_t                 state_r,   state_next;
  logic                   target_r,  target_next;
  logic                   pb_r,      pb_next;
  logic                   busy_r,    busy_next;
  logic                   settled_r, settled_next;
  logic [15:0]            window_r,  window_next;
  logic [HOLD_BITS-1:0]   seg_r,     seg_next;
  logic [15:0]            lfsr_r,    lfsr_next;
  logic                   change_s;
  logic                   toggle_s;
`ifdef BOUNCE_COUNT_EN
  logic [7:0]             cnt_r,     cnt_next;
`endif

  // Galois step, polynomial x^16+x^14+x^13+x^11+1.
  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    logic [15:0] nxt;
    nxt = {1'b0, cur[15:1]};
    if (cur[0]) begin
      nxt = nxt ^ 16'hB400;
    end else begin
      nxt = nxt;
    end
    return nxt;
  endfunction

  assign change_s = (clean_in != target_r);

  // Next-state and next-output logic for the bounce FSM.
  always_comb begin
    state_next   = state_r;
    target_next  = target_r;
    pb_next      = pb_r;
    busy_next    = busy_r;
    settled_next = 1'b0;
    window_next  = window_r;
    seg_next     = seg_r;
    lfsr_next    = lfsr_step(lfsr_r);
    toggle_s     = 1'b0;

    case (state_r)
      IDLE: begin
        busy_next = 1'b0;
        if (change_s) begin
          target_next = clean_in;
          pb_next     = clean_in;
          window_next = WIN_LOAD;
          seg_next    = lfsr_r[HOLD_BITS-1:0];
          busy_next   = 1'b1;
          state_next  = BOUNCE;
        end else begin
          pb_next = target_r;
        end
      end
      BOUNCE: begin
        if (change_s) begin
          // Retrigger: the abandoned target never gets a settled pulse.
          target_next = clean_in;
          pb_next     = clean_in;
          window_next = WIN_LOAD;
          seg_next    = lfsr_r[HOLD_BITS-1:0];
          busy_next   = 1'b1;
        end else if (window_r == 16'd0) begin
          pb_next      = target_r;
          busy_next    = 1'b0;
          settled_next = 1'b1;
          state_next   = IDLE;
        end else begin
          window_next = window_r - 16'd1;
          if (seg_r == {HOLD_BITS{1'b0}}) begin
            pb_next  = ~pb_r;
            seg_next = lfsr_r[HOLD_BITS-1:0];
            toggle_s = 1'b1;
          end else begin
            seg_next = seg_r - {{(HOLD_BITS-1){1'b0}}, 1'b1};
          end
        end
      end
      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
        pb_next    = target_r;
      end
    endcase
  end

`ifdef BOUNCE_COUNT_EN
  // Saturating toggle counter, cleared on every change edge.
  always_comb begin
    cnt_next = cnt_r;
    if (change_s) begin
      cnt_next = 8'd0;
    end else if (toggle_s && (cnt_r != 8'hFF)) begin
      cnt_next = cnt_r + 8'd1;
    end else begin
      cnt_next = cnt_r;
    end
  end

  // Toggle counter register.
  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) begin
      cnt_r <= 8'd0;
    end else begin
      cnt_r <= cnt_next;
    end
  end

  assign bounce_count = cnt_r;
`endif

  // State, output and LFSR registers.
  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      target_r  <= 1'b0;
      pb_r      <= 1'b0;
      busy_r    <= 1'b0;
      settled_r <= 1'b0;
      window_r  <= 16'd0;
      seg_r     <= {HOLD_BITS{1'b0}};
      lfsr_r    <= SEED_EFF;
    end else begin
      state_r   <= state_next;
      target_r  <= target_next;
      pb_r      <= pb_next;
      busy_r    <= busy_next;
      settled_r <= settled_next;
      window_r  <= window_next;
      seg_r     <= seg_next;
      lfsr_r    <= lfsr_next;
    end
  end

  assign pb_out  = pb_r;
  assign busy    = busy_r;
  assign settled = settled_r;

endmodule
